// File: rtl/priority_decoder_2to4_hold.sv
// priority_decoder_2to4_hold
//   Registered 2-to-4 decoder with a valid/ready input handshake. Each
//   accepted index drives its one-hot line for HOLD_CYCLES cycles. A new
//   index can be taken in the last hold cycle, so indices stream with no gap.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in         encoded index, sampled only on accept
//   in_valid   in holds a valid index
//   in_ready   block can accept this cycle (depends on state only)
//   out        one-hot decode of the last accepted index, zero when idle
//   out_valid  out holds a live one-hot value
//   busy       block is in HOLD
//
// Parameters
//   IN_W         encoded index width
//   OUT_W        one-hot width, must equal 2**IN_W
//   HOLD_CYCLES  cycles each one-hot is held (>= 1)
//   CNT_W        hold counter width, 2**CNT_W > HOLD_CYCLES-1
module priority_decoder_2to4_hold #(
  parameter int IN_W        = 2,
  parameter int OUT_W       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Counter value loaded on every accept: cnt counts the hold cycles still
  // to come after the current one, so 0 marks the final hold cycle.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [OUT_W-1:0] out_n;
  logic             out_valid_n;
  logic [OUT_W-1:0] dec;
  logic             accept;

  // One comparator per output line. The decode only reaches a register
  // through the accept path, so an undefined index outside accept is
  // never captured.
  for (genvar i = 0; i < OUT_W; i++) begin : g_dec
    assign dec[i] = (in == IN_W'(i));
  end

  assign in_ready = (state == IDLE) || ((state == HOLD) && (cnt == '0));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == HOLD);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    out_n       = out;
    out_valid_n = out_valid;
    unique case (state)
      IDLE: begin
        out_n       = '0;
        out_valid_n = 1'b0;
        if (accept) begin
          state_n     = HOLD;
          out_n       = dec;
          out_valid_n = 1'b1;
          cnt_n       = RELOAD;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (accept) begin
          // Back-to-back index: reload without passing through IDLE.
          out_n       = dec;
          out_valid_n = 1'b1;
          cnt_n       = RELOAD;
        end else begin
          state_n     = IDLE;
          out_n       = '0;
          out_valid_n = 1'b0;
        end
      end
      default: begin
        state_n     = IDLE;
        cnt_n       = '0;
        out_n       = '0;
        out_valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      out       <= out_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_priority_decoder_2to4_hold.sv
module tb_priority_decoder_2to4_hold;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       chk_en = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  // instance a: HOLD_CYCLES=4, instance b: HOLD_CYCLES=1
  logic [1:0] in_a = '0, in_b = '0;
  logic       vld_a = 1'b0, vld_b = 1'b0;
  logic       rdy_a, rdy_b, ov_a, ov_b, busy_a, busy_b;
  logic [3:0] out_a, out_b;

  always #5 clk = ~clk;

  priority_decoder_2to4_hold #(.IN_W(2), .OUT_W(4), .HOLD_CYCLES(4), .CNT_W(3)) u_a (
    .clk(clk), .rst(rst), .in(in_a), .in_valid(vld_a), .in_ready(rdy_a),
    .out(out_a), .out_valid(ov_a), .busy(busy_a));

  priority_decoder_2to4_hold #(.IN_W(2), .OUT_W(4), .HOLD_CYCLES(1), .CNT_W(1)) u_b (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(vld_b), .in_ready(rdy_b),
    .out(out_b), .out_valid(ov_b), .busy(busy_b));

  // ---------------- reference model ----------------
  // Time-based view: e = rising edges since reset, acc = edge of the most
  // recent accept. Output is live for the H cycles following an accept;
  // the next index can be taken once e - acc >= H-1.
  int         e_a = 0, e_b = 0;
  int         acc_a = -100, acc_b = -100;
  logic [1:0] idx_a = '0, idx_b = '0;

  function automatic logic m_ready(int e, int acc, int h);
    return (e - acc) >= (h - 1);
  endfunction

  function automatic logic m_valid(int e, int acc, int h);
    return (e - acc) >= 0 && (e - acc) < h;
  endfunction

  function automatic logic [3:0] m_out(int e, int acc, logic [1:0] idx, int h);
    return m_valid(e, acc, h) ? (4'b0001 << idx) : 4'b0000;
  endfunction

  // 4-to-2 priority encoder feeding instance b in the chained sweep
  function automatic logic [1:0] enc(logic [3:0] x);
    for (int i = 3; i >= 0; i--) if (x[i]) return 2'(i);
    return 2'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_a <= 0; e_b <= 0; acc_a <= -100; acc_b <= -100;
    end else begin
      e_a <= e_a + 1;
      e_b <= e_b + 1;
      if (vld_a && m_ready(e_a, acc_a, 4)) begin acc_a <= e_a + 1; idx_a <= in_a; end
      if (vld_b && m_ready(e_b, acc_b, 1)) begin acc_b <= e_b + 1; idx_b <= in_b; end
    end
  end

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("a.out",       out_a,        m_out(e_a, acc_a, idx_a, 4));
      check("a.out_valid", {3'b0, ov_a}, {3'b0, m_valid(e_a, acc_a, 4)});
      check("a.busy",      {3'b0, busy_a}, {3'b0, m_valid(e_a, acc_a, 4)});
      check("a.in_ready",  {3'b0, rdy_a}, {3'b0, m_ready(e_a, acc_a, 4)});
      check("b.out",       out_b,        m_out(e_b, acc_b, idx_b, 1));
      check("b.out_valid", {3'b0, ov_b}, {3'b0, m_valid(e_b, acc_b, 1)});
      check("b.busy",      {3'b0, busy_b}, {3'b0, m_valid(e_b, acc_b, 1)});
      check("b.in_ready",  {3'b0, rdy_b}, {3'b0, m_ready(e_b, acc_b, 1)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe_a(string name, logic [3:0] exp_out, logic exp_rdy);
    @(negedge clk);
    check({name, ".out"}, out_a, exp_out);
    check({name, ".rdy"}, {3'b0, rdy_a}, {3'b0, exp_rdy});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst.out_a", out_a, 4'b0000);
    check("rst.rdy_a", {3'b0, rdy_a}, 4'b0001);
    rst = 1'b0;
    chk_en = 1'b1;

    // single index from IDLE, held 4 cycles
    step(); vld_a = 1'b1; in_a = 2'b11;
    step(); vld_a = 1'b0;
    probe_a("t2.h1", 4'b1000, 1'b0);
    step(); probe_a("t2.h2", 4'b1000, 1'b0);
    step(); probe_a("t2.h3", 4'b1000, 1'b0);
    step(); probe_a("t2.h4", 4'b1000, 1'b1);
    step(); probe_a("t2.idle", 4'b0000, 1'b1);

    // back-to-back with in_valid held: 0 then 2, no idle gap
    step(); vld_a = 1'b1; in_a = 2'b00;
    step(); in_a = 2'b10;
    for (int i = 0; i < 4; i++) begin
      probe_a("t3.first", 4'b0001, i == 3);
      step();
    end
    vld_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      probe_a("t3.second", 4'b0100, i == 3);
      step();
    end
    probe_a("t3.idle", 4'b0000, 1'b1);

    // request while cnt=2 is ignored, hold ends on schedule
    step(); vld_a = 1'b1; in_a = 2'b00;
    step(); vld_a = 1'b0;
    step(); vld_a = 1'b1; in_a = 2'b01;
    step(); vld_a = 1'b0;
    probe_a("t4.h3", 4'b0001, 1'b0);
    step(); probe_a("t4.h4", 4'b0001, 1'b1);
    step(); probe_a("t4.idle", 4'b0000, 1'b1);

    // async reset mid-hold (cnt=2, out=0100)
    step(); vld_a = 1'b1; in_a = 2'b10;
    step(); vld_a = 1'b0;
    step();
    check("t1.pre", out_a, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("t1.out",   out_a, 4'b0000);
    check("t1.valid", {3'b0, ov_a},   4'b0000);
    check("t1.rdy",   {3'b0, rdy_a},  4'b0001);
    check("t1.busy",  {3'b0, busy_a}, 4'b0000);
    @(negedge clk); rst = 1'b0;

    // HOLD_CYCLES=1 stream 0,1,2,3
    step();
    for (int i = 0; i < 4; i++) begin
      vld_b = 1'b1; in_b = 2'(i);
      step();
      @(negedge clk);
      check("t5.out", out_b, 4'b0001 << i);
      check("t5.rdy", {3'b0, rdy_b}, 4'b0001);
    end
    step(); vld_b = 1'b0;

    // chained behind the priority encoder, sweep 0..15
    for (int x = 0; x < 16; x++) begin
      vld_b = (x != 0); in_b = enc(4'(x));
      step();
      if (x == 6)  check("t6.x6",  out_b, 4'b0100);
      if (x == 0)  check("t6.x0",  out_b, 4'b0000);
      if (x == 9)  check("t6.x9",  out_b, 4'b1000);
    end
    vld_b = 1'b0;

    // random traffic on both instances
    for (int n = 0; n < 2000; n++) begin
      vld_a = ($urandom_range(0, 3) != 0);
      in_a  = 2'($urandom_range(0, 3));
      vld_b = ($urandom_range(0, 2) != 0);
      in_b  = 2'($urandom_range(0, 3));
      step();
    end
    vld_a = 1'b0; vld_b = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk_en = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
